registrador_universal: RTL
==========================

Name: registrador_universal

Overview:
- Parametrised universal shift register, WIDTH bits, one clock domain.
- Four modes: hold, shift right, shift left, parallel load. Provides a serial input and output at each end, and a parallel output.
- Contains a shift-frame counter with a one-cycle frame_done pulse, so the block can act as a serialiser/deserialiser between serial links and parallel datapaths.
- Supersedes the fixed 4-bit serial-in shift chain.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32.
- RESET_VALUE, 0, value of q after reset and after clear; WIDTH bits.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = block updates this edge; 0 = all state frozen.
- clear  in  1  synchronous clear; valid only when enable=1.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- serial_in_r  in  1  bit entering the MSB on shift right.
- serial_in_l  in  1  bit entering the LSB on shift left.
- data_in  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents, registered.
- serial_out_r  out  1  equals q[0]; the bit leaving on the next shift right.
- serial_out_l  out  1  equals q[WIDTH-1]; the bit leaving on the next shift left.
- shift_count  out  $clog2(WIDTH)  shifts performed since the last load, clear or frame completion.
- frame_done  out  1  registered pulse, high for exactly one cycle after the WIDTH-th shift of a frame.

Behaviour:
- Reset:
  - reset_n=0 forces q=RESET_VALUE, shift_count=0, frame_done=0 immediately, independent of clock.
  - Release is synchronous to the next rising edge; the first update occurs at the first edge with reset_n=1.
- enable=0: q and shift_count hold, frame_done=0. All other inputs are ignored, including clear.
- When enable=1, the priority per edge is clear > mode:
  - clear=1: q=RESET_VALUE, shift_count=0, frame_done=0, regardless of mode.
  - mode 00 (hold): q and shift_count unchanged, frame_done=0.
  - mode 01 (shift right): q <= {serial_in_r, q[WIDTH-1:1]}. Data moves toward the LSB, and q[0] is discarded.
  - mode 10 (shift left): q <= {q[WIDTH-2:0], serial_in_l}. Data moves toward the MSB, and q[WIDTH-1] is discarded.
  - mode 11 (parallel load): q <= data_in, shift_count=0, frame_done=0.
- Counter, on shift modes only:
  - If shift_count == WIDTH-1: shift_count wraps to 0 and frame_done=1 in the same edge.
  - Otherwise shift_count increments and frame_done=0.
  - Both shift directions count toward the same frame; changing direction mid-frame does not reset the count.
- frame_done:
  - Goes high on the same edge that completes the WIDTH-th shift, so q holds the full deserialised word while frame_done=1.
  - Latency is zero cycles from the completing edge.
  - Never high for two consecutive cycles unless two frames complete back-to-back, which requires WIDTH=1 and is therefore illegal.
- serial_out_r and serial_out_l are direct wires from q; they introduce no extra register.
- Reset asserted mid-frame: the partial count is lost, and the next frame starts from 0.
- Load mid-frame: the count restarts, and WIDTH further shifts are needed for frame_done.
- Illegal mode values do not exist, since the 2-bit encoding is complete.

Test Plan:
- WIDTH=4. Assert reset_n=0 between clock edges after loading 4'b1111 -> q=0000, shift_count=0, frame_done=0 before the next edge.
- WIDTH=4, mode=01, serial_in_r = 1,0,1,1 over four edges -> q = 1000, 0100, 1010, 1101. shift_count = 1,2,3,0. frame_done=1 only after the 4th edge, back to 0 on the 5th edge.
- WIDTH=4, load data_in=1001, then mode=10 with serial_in_l=0 for two edges -> q = 0010, 0100. serial_out_l = 1, 0, 0. shift_count = 0, 1, 2.
- WIDTH=4, q=1010, mode=01, enable=0 for 3 edges -> q stays 1010, shift_count unchanged, frame_done=0. Also with clear=1, enable=0 -> q unchanged.
- WIDTH=4: 2 shifts, then clear=1 with mode=11 and data_in=0110 -> q=0000, count=0. Next, load 0110 and 2 shifts -> no frame_done; 2 more shifts -> frame_done pulses.
- WIDTH=8, RESET_VALUE=8'hA5: reset -> q=A5. 16 consecutive right shifts of 0 -> frame_done pulses after the 8th and 16th edges, and q=00 at the end.

Source files
------------

// File: rtl/registrador_universal_if.sv
// Bus bundle for the universal shift register: control, serial and parallel data
// towards the register, and its registered state back out.
interface registrador_universal_if #(
    parameter int WIDTH = 4
);
    logic                       enable;
    logic                       clear;
    logic [1:0]                 mode;
    logic                       serial_in_r;
    logic                       serial_in_l;
    logic [WIDTH-1:0]           data_in;
    logic [WIDTH-1:0]           q;
    logic                       serial_out_r;
    logic                       serial_out_l;
    logic [$clog2(WIDTH)-1:0]   shift_count;
    logic                       frame_done;

    modport master (
        output enable, clear, mode, serial_in_r, serial_in_l, data_in,
        input  q, serial_out_r, serial_out_l, shift_count, frame_done
    );

    modport slave (
        input  enable, clear, mode, serial_in_r, serial_in_l, data_in,
        output q, serial_out_r, serial_out_l, shift_count, frame_done
    );
endinterface

// File: rtl/registrador_universal.sv
// Universal shift register with hold/shift-right/shift-left/load modes and a
// shift-frame counter whose frame_done pulse marks each completed WIDTH-bit word.
module registrador_universal #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    registrador_universal_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic             isShift;

    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        done_d  = 1'b0;
        isShift = 1'b0;
        if (bus.enable) begin
            if (bus.clear) begin
                q_d     = RESET_VALUE;
                count_d = '0;
            end else begin
                case (bus.mode)
                    MODE_HOLD: ;
                    MODE_RIGHT: begin
                        q_d     = {bus.serial_in_r, q_q[WIDTH-1:1]};
                        isShift = 1'b1;
                    end
                    MODE_LEFT: begin
                        q_d     = {q_q[WIDTH-2:0], bus.serial_in_l};
                        isShift = 1'b1;
                    end
                    MODE_LOAD: begin
                        q_d     = bus.data_in;
                        count_d = '0;
                    end
                    default: ;
                endcase
            end
            // Both directions share one frame; the WIDTH-th shift wraps and flags the word.
            if (isShift) begin
                if (count_q == LAST) begin
                    count_d = '0;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q     <= RESET_VALUE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign bus.q            = q_q;
    assign bus.serial_out_r = q_q[0];
    assign bus.serial_out_l = q_q[WIDTH-1];
    assign bus.shift_count  = count_q;
    assign bus.frame_done   = done_q;
endmodule
